// File: rtl/inst_loader.sv
// inst_loader: turns a framed UART byte stream into instruction-memory writes.
// Frame: SYNC, LEN (words), LEN*(DWIDTH/8) data bytes MSB first, CHK (XOR of
// LEN and every data byte). A good frame ends with an ap_start pulse; a bad
// or stalled frame sets the sticky err flag and drops back to IDLE.
module inst_loader #(
  parameter int         DWIDTH  = 16,
  parameter int         AWIDTH  = 8,
  parameter int         TIMEOUT = 1000000,
  parameter logic [7:0] SYNC    = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [DWIDTH-1:0] user_inst_write,
  output logic [AWIDTH-1:0] user_inst_addr,
  output logic              user_inst_wen,
  output logic              ap_stop,
  output logic              ap_start,
  output logic              busy,
  output logic              err,
  output logic [AWIDTH:0]   inst_count
);

  localparam int BPW       = DWIDTH / 8;                       // bytes per word
  localparam int BIW       = (BPW > 1) ? $clog2(BPW) : 1;      // byte index width
  localparam int TW        = $clog2(TIMEOUT + 1);              // idle timer width
  localparam int CW        = AWIDTH + 1;                       // word count width
  localparam int MAX_WORDS = 1 << AWIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CHK,
    S_START
  } state_t;

  state_t          state;
  state_t          next_state;

  logic [BIW-1:0]  byte_idx;
  logic [CW-1:0]   len_q;
  logic [7:0]      chk_q;
  logic [TW-1:0]   timer;

  logic            start_frame;
  logic            load_len;
  logic            take_byte;
  logic            word_done;
  logic            set_err;
  logic            len_bad;
  logic            timeout_hit;

  // LEN must describe at least one word and no more than the memory holds,
  // which is also what keeps the address arithmetic from ever wrapping.
  assign len_bad     = (rx_data == 8'd0) || ({24'd0, rx_data} > MAX_WORDS);
  assign timeout_hit = !rx_valid && (timer == TW'(TIMEOUT - 1));

  assign ap_start = (state == S_START);
  assign busy     = (state != S_IDLE);

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would make results depend on block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state decode and the per-byte control strobes for the datapath.
  // NOTE: every signal gets a default first so no path leaves it unassigned;
  // a missing default in always_comb infers a latch.
  always_comb begin
    next_state  = state;
    start_frame = 1'b0;
    load_len    = 1'b0;
    take_byte   = 1'b0;
    word_done   = 1'b0;
    set_err     = 1'b0;
    case (state)
      // START behaves like IDLE for an incoming byte so a SYNC arriving in the
      // ap_start cycle is not lost.
      S_IDLE, S_START: begin
        next_state = S_IDLE;
        if (rx_valid && rx_data == SYNC) begin
          start_frame = 1'b1;
          next_state  = S_LEN;
        end
      end
      S_LEN: begin
        if (rx_valid) begin
          if (len_bad) begin
            set_err    = 1'b1;
            next_state = S_IDLE;
          end else begin
            load_len   = 1'b1;
            next_state = S_DATA;
          end
        end else if (timeout_hit) begin
          set_err    = 1'b1;
          next_state = S_IDLE;
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          take_byte = 1'b1;
          if (byte_idx == BIW'(BPW - 1)) begin
            word_done = 1'b1;
            if (inst_count + CW'(1) == len_q) next_state = S_CHK;
          end
        end else if (timeout_hit) begin
          set_err    = 1'b1;
          next_state = S_IDLE;
        end
      end
      S_CHK: begin
        if (rx_valid) begin
          if (rx_data == chk_q) begin
            next_state = S_START;
          end else begin
            set_err    = 1'b1;
            next_state = S_IDLE;
          end
        end else if (timeout_hit) begin
          set_err    = 1'b1;
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Idle timer: cleared by every byte, runs only while a frame is open.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (rx_valid) begin
      timer <= '0;
    end else if (state == S_LEN || state == S_DATA || state == S_CHK) begin
      timer <= timer + TW'(1);
    end else begin
      timer <= '0;
    end
  end

  // Datapath: word assembly, checksum, write strobe, counters and err flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      user_inst_write <= '0;
      user_inst_addr  <= '0;
      user_inst_wen   <= 1'b0;
      ap_stop         <= 1'b0;
      err             <= 1'b0;
      inst_count      <= '0;
      byte_idx        <= '0;
      len_q           <= '0;
      chk_q           <= '0;
    end else begin
      user_inst_wen <= word_done;
      ap_stop       <= start_frame;

      if (start_frame) begin
        err             <= 1'b0;
        inst_count      <= '0;
        byte_idx        <= '0;
        chk_q           <= '0;
        user_inst_write <= '0;
      end

      if (set_err) err <= 1'b1;

      if (load_len) begin
        len_q    <= CW'(rx_data);
        chk_q    <= rx_data;
        byte_idx <= '0;
      end

      // The word register is also the write-data port: it holds the full word
      // during the wen cycle and only starts shifting on the next byte.
      if (take_byte) begin
        user_inst_write <= (user_inst_write << 8) | DWIDTH'(rx_data);
        chk_q           <= chk_q ^ rx_data;
        byte_idx        <= word_done ? '0 : byte_idx + BIW'(1);
      end

      if (word_done) begin
        user_inst_addr <= inst_count[AWIDTH-1:0];
        inst_count     <= inst_count + CW'(1);
      end
    end
  end

endmodule
